// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the rPLL reset, qualifies lock on the free-running
// crystal clock, then releases the PLL-domain system reset and watches for lock loss.
module pll_reset_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_STABLE   = 1024,
   parameter int LOCK_TIMEOUT  = 270000,
   parameter int RELEASE_DELAY = 256,
   parameter int LOSS_FILTER   = 4,
   parameter int MAX_RETRY     = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_lock,
   input  logic       restart,
   output logic       pll_reset,
   output logic       sys_rst_n,
   output logic       pll_ok,
   output logic       fault,
   output logic [7:0] loss_count,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_RELEASE   = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   localparam logic [19:0] C_RST_LAST     = 20'(RST_CYCLES - 1);
   localparam logic [19:0] C_STABLE_LAST  = 20'(LOCK_STABLE - 1);
   localparam logic [19:0] C_TIMEOUT_LAST = 20'(LOCK_TIMEOUT - 1);
   localparam logic [19:0] C_RELEASE      = 20'(RELEASE_DELAY);
   localparam logic [7:0]  C_LOSS_LAST    = 8'(LOSS_FILTER - 1);
   localparam logic [3:0]  C_MAX_RETRY    = 4'(MAX_RETRY);

   state_t      r_state;
   logic [19:0] r_cnt;
   logic [19:0] r_stable;
   logic [7:0]  r_low;
   logic [3:0]  r_retry;
   logic [7:0]  r_loss_count;
   logic        r_sync1;
   logic        r_lock_s;
   logic        r_pll_reset;
   logic        r_sys_rst_n;
   logic        r_pll_ok;
   logic        r_fault;
   logic [3:0]  w_retry_inc;
   logic [7:0]  w_loss_inc;

   function automatic logic [19:0] sat_inc20(input logic [19:0] v);
      return (v == 20'hF_FFFF) ? v : v + 20'd1;
   endfunction

   assign w_retry_inc = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;
   assign w_loss_inc  = (r_loss_count == 8'hFF) ? r_loss_count : r_loss_count + 8'd1;

   // pll_lock comes from the PLL domain; only r_lock_s may be used for decisions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= 1'b0;
         r_lock_s <= 1'b0;
      end else begin
         r_sync1  <= pll_lock;
         r_lock_s <= r_sync1;
      end
   end

   // Outputs are loaded on the same edge as the state they belong to, so each
   // output is a registered decode of the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_PLL_RST;
         r_cnt        <= 20'd0;
         r_stable     <= 20'd0;
         r_low        <= 8'd0;
         r_retry      <= 4'd0;
         r_loss_count <= 8'd0;
         r_pll_reset  <= 1'b1;
         r_sys_rst_n  <= 1'b0;
         r_pll_ok     <= 1'b0;
         r_fault      <= 1'b0;
      end else if (restart) begin
         r_state     <= S_PLL_RST;
         r_cnt       <= 20'd0;
         r_stable    <= 20'd0;
         r_low       <= 8'd0;
         r_retry     <= 4'd0;
         r_pll_reset <= 1'b1;
         r_sys_rst_n <= 1'b0;
         r_pll_ok    <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         case (r_state)
            S_PLL_RST: begin
               if (r_cnt >= C_RST_LAST) begin
                  r_state     <= S_WAIT_LOCK;
                  r_cnt       <= 20'd0;
                  r_stable    <= 20'd0;
                  r_pll_reset <= 1'b0;
               end else begin
                  r_cnt <= sat_inc20(r_cnt);
               end
            end

            S_WAIT_LOCK: begin
               r_cnt    <= sat_inc20(r_cnt);
               r_stable <= r_lock_s ? sat_inc20(r_stable) : 20'd0;
               // Lock acceptance wins over a timeout landing on the same cycle.
               if (r_lock_s && (r_stable >= C_STABLE_LAST)) begin
                  r_state <= S_RELEASE;
                  r_cnt   <= 20'd0;
                  r_retry <= 4'd0;
               end else if (r_cnt >= C_TIMEOUT_LAST) begin
                  r_cnt       <= 20'd0;
                  r_retry     <= w_retry_inc;
                  r_pll_reset <= 1'b1;
                  if (w_retry_inc >= C_MAX_RETRY) begin
                     r_state <= S_FAULT;
                     r_fault <= 1'b1;
                  end else begin
                     r_state <= S_PLL_RST;
                  end
               end
            end

            S_RELEASE: begin
               if (!r_lock_s) begin
                  r_state     <= S_PLL_RST;
                  r_cnt       <= 20'd0;
                  r_pll_reset <= 1'b1;
               end else if (r_cnt >= C_RELEASE) begin
                  r_state     <= S_RUN;
                  r_cnt       <= 20'd0;
                  r_low       <= 8'd0;
                  r_sys_rst_n <= 1'b1;
                  r_pll_ok    <= 1'b1;
               end else begin
                  r_cnt <= sat_inc20(r_cnt);
               end
            end

            S_RUN: begin
               if (!r_lock_s) begin
                  if (r_low >= C_LOSS_LAST) begin
                     r_state      <= S_PLL_RST;
                     r_cnt        <= 20'd0;
                     r_low        <= 8'd0;
                     r_retry      <= 4'd0;
                     r_loss_count <= w_loss_inc;
                     r_pll_reset  <= 1'b1;
                     r_sys_rst_n  <= 1'b0;
                     r_pll_ok     <= 1'b0;
                  end else begin
                     r_low <= r_low + 8'd1;
                  end
               end else begin
                  r_low <= 8'd0;
               end
            end

            S_FAULT: begin
               r_state <= S_FAULT;
            end

            default: begin
               r_state     <= S_PLL_RST;
               r_cnt       <= 20'd0;
               r_pll_reset <= 1'b1;
               r_sys_rst_n <= 1'b0;
               r_pll_ok    <= 1'b0;
               r_fault     <= 1'b0;
            end
         endcase
      end
   end

   assign pll_reset  = r_pll_reset;
   assign sys_rst_n  = r_sys_rst_n;
   assign pll_ok     = r_pll_ok;
   assign fault      = r_fault;
   assign loss_count = r_loss_count;
   assign dbg_state  = r_state;

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles the PLL reset is held per attempt (1..2^20-1).
REQ-002 Parameter LOCK_STABLE, default 1024: consecutive synchronized lock-high cycles required before lock is accepted (1..2^20-1).
REQ-003 Parameter LOCK_TIMEOUT, default 270000: cycles allowed in WAIT_LOCK before a retry, 10 ms at 27 MHz (must be > LOCK_STABLE, < 2^20).
REQ-004 Parameter RELEASE_DELAY, default 256: cycles between lock acceptance and system reset release (0..2^20-1).
REQ-005 Parameter LOSS_FILTER, default 4: consecutive synchronized lock-low cycles in RUN that count as lock loss (1..255).
REQ-006 Parameter MAX_RETRY, default 3: lock timeouts tolerated per sequence before FAULT (1..15).
REQ-007 clk  input  1  free-running 27 MHz crystal clock; never the PLL output.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 pll_lock  input  1  rPLL LOCK; asynchronous to clk.
REQ-010 restart  input  1  synchronous one-cycle request to re-run the full sequence.
REQ-011 pll_reset  output  1  drives rPLL RESET, active-high.
REQ-012 sys_rst_n  output  1  active-low reset for logic clocked by the PLL outputs.
REQ-013 pll_ok  output  1  high only in RUN.
REQ-014 fault  output  1  high only in FAULT.
REQ-015 loss_count  output  8  saturating count of lock-loss events since rst_n.

Function
REQ-016 Two-flop synchronizer on pll_lock; all decisions use the synchronized value lock_s only.
REQ-017 States: PLL_RST, WAIT_LOCK, RELEASE, RUN, FAULT; one shared 20-bit cycle counter cnt; a 4-bit retry counter.
REQ-018 PLL_RST: pll_reset=1, sys_rst_n=0; after RST_CYCLES cycles in state -> WAIT_LOCK with cnt=0.
REQ-019 WAIT_LOCK: pll_reset=0, sys_rst_n=0; stable counter increments while lock_s=1 and clears to 0 on any lock_s=0 cycle.
REQ-020 WAIT_LOCK: stable counter reaching LOCK_STABLE -> RELEASE with retry=0; this takes priority over timeout in the same cycle.
REQ-021 WAIT_LOCK: cnt reaching LOCK_TIMEOUT -> retry+1; if the new retry equals MAX_RETRY -> FAULT, else -> PLL_RST.
REQ-022 RELEASE: sys_rst_n=0; lock_s=0 in any cycle -> PLL_RST immediately (no loss_count increment); after RELEASE_DELAY cycles -> RUN.
REQ-023 RUN: sys_rst_n=1, pll_ok=1; LOSS_FILTER consecutive lock_s=0 cycles -> PLL_RST, loss_count+1 (saturating at 255), retry=0.
REQ-024 sys_rst_n falls on the same clk edge that leaves RUN; it rises exactly one cycle after RELEASE completes (registered output).
REQ-025 FAULT: pll_reset=1, sys_rst_n=0, fault=1; exits only via restart or rst_n.
REQ-026 restart=1 in any state -> PLL_RST next cycle, cnt=0, retry=0; loss_count is preserved; restart has priority over every other transition.
REQ-027 All outputs registered; no combinational path from pll_lock or restart to any output.
REQ-028 Counters never wrap; every counter compare uses >= so that a mid-count parameter edge case cannot be skipped.

Reset
REQ-029 rst_n=0 asynchronously forces PLL_RST, cnt=0, retry=0, stable=0, loss_count=0, synchronizer=0, pll_reset=1, sys_rst_n=0, pll_ok=0, fault=0.
REQ-030 rst_n assertion during any state, including mid-RELEASE, drops sys_rst_n to 0 without waiting for clk.

Verification (bench params RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, RELEASE_DELAY=5, LOSS_FILTER=3, MAX_RETRY=2)
REQ-031 Lock high 10 cycles after rst_n release -> pll_reset high for exactly 4 cycles; sys_rst_n rises exactly 2+8+5+1 cycles after the first lock high edge; pll_ok=1.
REQ-032 In RUN, drop lock for 2 cycles -> no change; drop lock for 3 cycles -> sys_rst_n=0, pll_reset=1, loss_count=1.
REQ-033 Lock held low -> two PLL_RST pulses of 4 cycles each, then fault=1, pll_reset=1; pulse restart -> PLL_RST and fault=0 on the next cycle.
REQ-034 Lock toggling every 5 cycles in WAIT_LOCK -> never reaches RELEASE; timeout retries follow, as in REQ-033.
REQ-035 Lock drops during RELEASE -> PLL_RST, loss_count unchanged; rst_n pulse in RUN -> sys_rst_n=0 asynchronously and loss_count=0.
REQ-036 Force 260 loss events -> loss_count saturates at 255.
